vec_op_arbiter: RTL and testbench



---
 rtl/vec_math_pkg.sv | 31 +++
 rtl/vec_alu.sv | 58 +++++
 rtl/vec_op_arbiter.sv | 144 ++++++++++++++
 tb/tb_vec_op_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_math_pkg.sv
// Shared fixed-point vector types, opcodes, arbiter FSM states and a signed multiply helper.
package vec_math_pkg;

    localparam int Q_BITS_DEFAULT = 16;

    typedef logic signed [2:0][31:0] vec3_t;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_DOT   = 2'd1,
        OP_CROSS = 2'd2,
        OP_SCALE = 2'd3
    } vec_op_t;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2
    } arb_state_t;

    // Full-width signed product; both operands are sign-extended before multiplying.
    function automatic logic signed [63:0] mul64(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = a;
        eb = b;
        return ea * eb;
    endfunction

endpackage

// File: rtl/vec_alu.sv
// Combinational Q-format vector ALU: ADD, DOT, CROSS, SCALE; no saturation.
module vec_alu
    import vec_math_pkg::*;
#(
    parameter int Q_BITS = Q_BITS_DEFAULT
) (
    input  logic [1:0]  op_i,
    input  logic [95:0] x_i,
    input  logic [95:0] y_i,
    output logic [95:0] res_o
);

    vec3_t x;
    vec3_t y;
    vec3_t r;
    logic signed [63:0] dot_sum;
    logic signed [63:0] cr0;
    logic signed [63:0] cr1;
    logic signed [63:0] cr2;

    assign x = x_i;
    assign y = y_i;

    // Products are summed at full width and shifted once, so rounding happens only at the end.
    assign dot_sum = mul64(x[0], y[0]) + mul64(x[1], y[1]) + mul64(x[2], y[2]);
    assign cr0     = mul64(x[1], y[2]) - mul64(x[2], y[1]);
    assign cr1     = mul64(x[2], y[0]) - mul64(x[0], y[2]);
    assign cr2     = mul64(x[0], y[1]) - mul64(x[1], y[0]);

    function automatic logic [31:0] q_trunc(input logic signed [63:0] v);
        logic signed [63:0] t;
        t = v >>> Q_BITS;
        return t[31:0];
    endfunction

    always_comb begin
        r = '0;
        case (vec_op_t'(op_i))
            OP_ADD: begin
                for (int k = 0; k < 3; k++) r[k] = x[k] + y[k];
            end
            OP_DOT: begin
                r[0] = q_trunc(dot_sum);
            end
            OP_CROSS: begin
                r[0] = q_trunc(cr0);
                r[1] = q_trunc(cr1);
                r[2] = q_trunc(cr2);
            end
            OP_SCALE: begin
                for (int k = 0; k < 3; k++) r[k] = q_trunc(mul64(x[k], y[0]));
            end
        endcase
    end

    assign res_o = r;

endmodule

// File: rtl/vec_op_arbiter.sv
// Round-robin scheduler sharing one vec_alu among NUM_REQ requesters (pop -> exec -> write).
// Optional VEC_OP_ARBITER_STATS_EN adds per-requester write counters on grant_count.
module vec_op_arbiter
    import vec_math_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int Q_BITS  = Q_BITS_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_empty,
    output logic [NUM_REQ-1:0]         req_rd_en,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [96*NUM_REQ-1:0]      req_x,
    input  logic [96*NUM_REQ-1:0]      req_y,
    input  logic [NUM_REQ-1:0]         res_full,
    output logic [NUM_REQ-1:0]         res_wr_en,
    output logic [95:0]                res_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef VEC_OP_ARBITER_STATS_EN
    ,
    output logic [32*NUM_REQ-1:0]      grant_count
`endif
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [GW-1:0]       rr_q, rr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [1:0]          op_q, op_d;
    logic [95:0]         x_q, x_d;
    logic [95:0]         y_q, y_d;
    logic [95:0]         res_q, res_d;
    logic [95:0]         alu_res;
    logic [NUM_REQ-1:0]  eligible;
    logic [GW-1:0]       pick;
    logic [GW-1:0]       cand;
    logic                found;
    int                  idx;

    // A requester with a full result FIFO is never granted, so it cannot stall the others.
    assign eligible = ~req_empty & ~res_full;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = GW'(idx);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    vec_alu #(.Q_BITS(Q_BITS)) u_alu (
        .op_i  (op_q),
        .x_i   (x_q),
        .y_i   (y_q),
        .res_o (alu_res)
    );

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        res_d     = res_q;
        req_rd_en = '0;
        res_wr_en = '0;
        case (state_q)
            S_ARB: begin
                if (found) begin
                    // Pop strobe is gated by reset so nothing is consumed while held in reset.
                    req_rd_en[pick] = !reset;
                    grant_d         = pick;
                    op_d            = req_op[2*pick +: 2];
                    x_d             = req_x[96*pick +: 96];
                    y_d             = req_y[96*pick +: 96];
                    state_d         = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_res;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!res_full[grant_q]) begin
                    res_wr_en[grant_q] = 1'b1;
                    rr_d    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_ARB;
            rr_q    <= '0;
            grant_q <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
        end
    end

    assign busy     = (state_q != S_ARB);
    assign grant_id = grant_q;
    assign res_data = res_q;

`ifdef VEC_OP_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][31:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_WRITE && !res_full[grant_q]) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_vec_op_arbiter.sv
// Directed bench for vec_op_arbiter: FWFT operand FIFO models, scoreboard of expected writes.
module tb_vec_op_arbiter;

  localparam int NUM_REQ = 2;
  localparam int Q       = 16;

  typedef struct packed {
    logic [1:0]  op;
    logic [95:0] x;
    logic [95:0] y;
  } req_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_empty = 2'b11;
  logic [1:0]   req_rd_en;
  logic [3:0]   req_op = '0;
  logic [191:0] req_x = '0;
  logic [191:0] req_y = '0;
  logic [1:0]   res_full = 2'b00;
  logic [1:0]   res_wr_en;
  logic [95:0]  res_data;
  logic         busy;
  logic [0:0]   grant_id;
`ifdef VEC_OP_ARBITER_STATS_EN
  logic [63:0]  grant_count;
`endif

  vec_op_arbiter #(.NUM_REQ(NUM_REQ), .Q_BITS(Q)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_empty (req_empty),
    .req_rd_en (req_rd_en),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .res_full  (res_full),
    .res_wr_en (res_wr_en),
    .res_data  (res_data),
    .busy      (busy),
    .grant_id  (grant_id)
`ifdef VEC_OP_ARBITER_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- bench state ----------------
  req_t         fifo0[$];
  req_t         fifo1[$];
  logic [1:0]   hold_empty  = 2'b00;
  logic [1:0]   pop_pending = 2'b00;
  logic [96:0]  exp_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           cyc    = 0;
  int           rd_cyc[$];
  int           rd_id[$];
  int           wr_cyc[$];
  int           wr_id[$];
  logic [95:0]  wr_data[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model written straight from the operation definitions on 64-bit signed ints.
  function automatic logic [95:0] model(input logic [1:0] op, input logic [95:0] xv,
                                        input logic [95:0] yv);
    longint xs[3];
    longint ys[3];
    longint r[3];
    logic [95:0] out;
    for (int k = 0; k < 3; k++) begin
      xs[k] = longint'($signed(xv[32*k +: 32]));
      ys[k] = longint'($signed(yv[32*k +: 32]));
      r[k]  = 0;
    end
    case (op)
      2'd0: for (int k = 0; k < 3; k++) r[k] = xs[k] + ys[k];
      2'd1: r[0] = (xs[0]*ys[0] + xs[1]*ys[1] + xs[2]*ys[2]) >>> Q;
      2'd2: begin
        r[0] = (xs[1]*ys[2] - xs[2]*ys[1]) >>> Q;
        r[1] = (xs[2]*ys[0] - xs[0]*ys[2]) >>> Q;
        r[2] = (xs[0]*ys[1] - xs[1]*ys[0]) >>> Q;
      end
      default: for (int k = 0; k < 3; k++) r[k] = (xs[k]*ys[0]) >>> Q;
    endcase
    for (int k = 0; k < 3; k++) out[32*k +: 32] = r[k][31:0];
    return out;
  endfunction

  function automatic void refresh();
    req_empty[0] = (fifo0.size() == 0) || hold_empty[0];
    req_empty[1] = (fifo1.size() == 0) || hold_empty[1];
    req_op  = '0;
    req_x   = '0;
    req_y   = '0;
    if (fifo0.size() != 0) begin
      req_op[1:0]  = fifo0[0].op;
      req_x[95:0]  = fifo0[0].x;
      req_y[95:0]  = fifo0[0].y;
    end
    if (fifo1.size() != 0) begin
      req_op[3:2]    = fifo1[0].op;
      req_x[191:96]  = fifo1[0].x;
      req_y[191:96]  = fifo1[0].y;
    end
  endfunction

  // ---------------- FIFO pop side ----------------
  always @(posedge clock) begin
    cyc = cyc + 1;
    #1;
    if (pop_pending[0] && fifo0.size() != 0) void'(fifo0.pop_front());
    if (pop_pending[1] && fifo1.size() != 0) void'(fifo1.pop_front());
    pop_pending = 2'b00;
    refresh();
  end

  // ---------------- monitor / scoreboard ----------------
  int          m_id;
  logic [96:0] m_e;
  req_t        m_h;

  always @(negedge clock) begin
    check("rd_onehot", {127'd0, $onehot0(req_rd_en)}, 128'd1);
    check("wr_onehot", {127'd0, $onehot0(res_wr_en)}, 128'd1);
    if (res_wr_en != 2'b00) begin
      m_id = res_wr_en[1] ? 1 : 0;
      wr_cyc.push_back(cyc);
      wr_id.push_back(m_id);
      wr_data.push_back(res_data);
      check("wr_expected", {127'd0, exp_q.size() != 0}, 128'd1);
      if (exp_q.size() != 0) begin
        m_e = exp_q.pop_front();
        check("wr_id", m_id, {127'd0, m_e[96]});
        check("wr_data", res_data, m_e[95:0]);
      end
    end
    if (req_rd_en != 2'b00) begin
      m_id = req_rd_en[1] ? 1 : 0;
      rd_cyc.push_back(cyc);
      rd_id.push_back(m_id);
      m_h = (m_id == 0) ? fifo0[0] : fifo1[0];
      exp_q.push_back({m_id[0], model(m_h.op, m_h.x, m_h.y)});
      pop_pending[m_id] = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push_req(input int r, input logic [1:0] op, input logic [95:0] x,
                          input logic [95:0] y);
    req_t e;
    e.op = op;
    e.x  = x;
    e.y  = y;
    if (r == 0) fifo0.push_back(e);
    else        fifo1.push_back(e);
    refresh();
  endtask

  task automatic wait_wr(input int target, input int budget, input string tag);
    int n = 0;
    while (wr_cyc.size() < target && n < budget) begin
      step();
      n++;
    end
    check(tag, wr_cyc.size(), target);
  endtask

  task automatic wait_rd(input int target, input int budget, input string tag);
    int n = 0;
    while (rd_cyc.size() < target && n < budget) begin
      step();
      n++;
    end
    check(tag, rd_cyc.size(), target);
  endtask

  task automatic single(input int r, input logic [1:0] op, input logic [95:0] x,
                        input logic [95:0] y, input logic [95:0] exp, input string tag);
    int wb = wr_cyc.size();
    int rb = rd_cyc.size();
    push_req(r, op, x, y);
    wait_wr(wb + 1, 20, {tag, "_timeout"});
    if (wr_cyc.size() > wb && rd_cyc.size() > rb) begin
      check({tag, "_data"}, wr_data[wb], exp);
      check({tag, "_id"}, wr_id[wb], r);
      check({tag, "_latency"}, wr_cyc[wb] - rd_cyc[rb], 2);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wb;
    int rb;
    int rel_cyc;
    logic [95:0] held;

    refresh();
    step();
    step();
    @(negedge clock);
    #1;
    check("rst_rd_en", req_rd_en, 0);
    check("rst_wr_en", res_wr_en, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    step();
    reset = 1'b0;
    step();

    single(0, 2'd1, {32'h30000, 32'h20000, 32'h10000}, {32'h60000, 32'h50000, 32'h40000},
           {32'h0, 32'h0, 32'h200000}, "dot");
    single(1, 2'd2, {32'h0, 32'h0, 32'h10000}, {32'h0, 32'h10000, 32'h0},
           {32'h10000, 32'h0, 32'h0}, "cross");
    single(0, 2'd3, {32'h8000, 32'hFFFE0000, 32'h10000}, {32'h0, 32'h0, 32'h20000},
           {32'h10000, 32'hFFFC0000, 32'h20000}, "scale");
    single(1, 2'd0, {32'hFFFFFFFF, 32'h1, 32'h7FFFFFFF}, {32'h1, 32'h1, 32'h1},
           {32'h0, 32'h2, 32'h80000000}, "add");

    // Fairness: four requests per requester, grants must alternate starting at 0.
    do_reset();
`ifdef VEC_OP_ARBITER_STATS_EN
    check("stats_after_reset", grant_count, 0);
`endif
    wb = wr_cyc.size();
    rb = rd_cyc.size();
    for (int i = 0; i < 4; i++) begin
      push_req(0, 2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom});
      push_req(1, 2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom});
    end
    wait_wr(wb + 8, 60, "fair_timeout");
    if (wr_cyc.size() >= wb + 8) begin
      for (int j = 0; j < 8; j++) check("fair_order", wr_id[wb + j], j % 2);
      check("fair_span", wr_cyc[wb + 7] - rd_cyc[rb], 23);
    end
`ifdef VEC_OP_ARBITER_STATS_EN
    check("stats_req0", grant_count[31:0], 4);
    check("stats_req1", grant_count[63:32], 4);
`endif

    // Skip on full: requester 0 must be bypassed while its result FIFO is full.
    res_full = 2'b01;
    wb = wr_cyc.size();
    for (int i = 0; i < 2; i++) begin
      push_req(0, 2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom});
      push_req(1, 2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom});
    end
    wait_wr(wb + 2, 20, "skip_timeout");
    if (wr_cyc.size() >= wb + 2) begin
      check("skip_id0", wr_id[wb], 1);
      check("skip_id1", wr_id[wb + 1], 1);
    end
    rb = rd_cyc.size();
    repeat (4) step();
    check("skip_no_pop", rd_cyc.size(), rb);
    check("skip_fifo0_kept", fifo0.size(), 2);
    res_full = 2'b00;
    rel_cyc = cyc;
    wb = wr_cyc.size();
    wait_wr(wb + 2, 20, "release_timeout");
    if (rd_cyc.size() > rb) begin
      check("release_id", rd_id[rb], 0);
      check("release_cycle", rd_cyc[rb], rel_cyc);
    end

    // Stall in S_WRITE: result held, no write until res_full drops, then exactly one.
    rb = rd_cyc.size();
    wb = wr_cyc.size();
    push_req(0, 2'd0, {32'h3, 32'h2, 32'h1}, {32'h30, 32'h20, 32'h10});
    wait_rd(rb + 1, 10, "stall_pop_timeout");
    res_full = 2'b01;
    step();
    held = res_data;
    check("stall_data", held, {32'h33, 32'h22, 32'h11});
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold", res_data, held);
      check("stall_busy", busy, 1);
      check("stall_grant", grant_id, 0);
    end
    check("stall_no_write", wr_cyc.size(), wb);
    res_full = 2'b00;
    repeat (4) step();
    check("stall_one_write", wr_cyc.size(), wb + 1);

    // Reset while in S_EXEC: in-flight result is lost, rr pointer restarts at 0.
    rb = rd_cyc.size();
    wb = wr_cyc.size();
    push_req(1, 2'd0, {32'h5, 32'h5, 32'h5}, {32'h5, 32'h5, 32'h5});
    wait_rd(rb + 1, 10, "rst_pop_timeout");
    hold_empty = 2'b11;
    refresh();
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("midrst_rd_en", req_rd_en, 0);
    check("midrst_wr_en", res_wr_en, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_lost", exp_q.size(), 1);
    exp_q.delete();
    step();
    reset = 1'b0;
    repeat (5) step();
    check("midrst_no_write", wr_cyc.size(), wb);
    rb = rd_cyc.size();
    push_req(0, 2'd2, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    push_req(1, 2'd1, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    hold_empty = 2'b00;
    refresh();
    wait_wr(wb + 2, 20, "postrst_timeout");
    if (rd_cyc.size() > rb) check("postrst_first_grant", rd_id[rb], 0);

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
